mii_rx_deframer: RTL and testbench
==================================

// Module: mii_rx_deframer
// PURPOSE
//  Parametrised MII/GMII receive deframer: strips preamble/SFD, assembles bytes, filters on destination MAC,
//  optionally strips FCS, emits a byte stream with sof/eof/err markers and per-frame length. Sits between the
//  MII pin sampler (which provides rx_ce) and the UART/packet-dump logic. Supports 4-bit (MII) and 8-bit (GMII) lanes.
// PARAMETERS
//  DW        4                 rx_d width; 4 = MII nibbles (low nibble first, rx_d[i] = byte bit i), 8 = GMII bytes
//  MAC_ADDR  48'h54ff01212324  station address; first wire byte = MAC_ADDR[47:40]
//  PROMISC   0                 1 = accept all destinations
//  STRIP_FCS 0                 1 = last 4 bytes (FCS) not emitted
//  MIN_LEN   64                min frame bytes (dst..FCS inclusive); shorter -> err
//  MAX_LEN   1518              max frame bytes; longer -> err, length saturates at 2047
//  CNT_W     16                statistics counter width
// PORTS
//  clk        in   1      system clock
//  SW0        in   1      reset, asynchronous, active-high
//  rx_ce      in   1      one-clk strobe per MII/GMII sample (rx_en/rx_er/rx_d sampled only when high)
//  rx_en      in   1      MII RX_DV
//  rx_er      in   1      MII RX_ER
//  rx_d       in   DW     MII data
//  out_data   out  8      frame byte
//  out_valid  out  1      out_data valid, one-clk pulse per byte
//  out_sof    out  1      with out_valid: first byte of frame
//  out_eof    out  1      with out_valid: last byte of frame
//  out_err    out  1      with out_eof: frame bad (runt, oversize, rx_er, dribble nibble)
//  out_len    out  11     with out_eof: total received bytes dst..FCS (pre-strip)
//  frame_cnt  out  CNT_W  delivered frames with err=0, wraps
//  drop_cnt   out  CNT_W  filtered frames + frames ending before dst complete, wraps
// BEHAVIOUR
//  - Reset: every output 0, state IDLE, counters 0, delay line empty. Reset mid-frame: frame discarded, no eof.
//  - All rx_* inputs ignored when rx_ce=0; outputs registered, 1 clk after the rx_ce completing a byte.
//  - FSM: IDLE -> PRE when rx_en & preamble unit (DW4: 4'h5, DW8: 8'h55).
//    PRE -> DATA on SFD (DW4: 4'h5 then 4'hD; DW8: 8'hD5) after >=1 preamble unit; any other value or rx_en=0 -> IDLE.
//    DATA: assemble bytes (DW4: low nibble then high). Bytes 1-6 compared to MAC_ADDR; after byte 6,
//    accept if match | broadcast (all FF) | multicast (byte1 bit0) | PROMISC, else -> DROP.
//    DATA/DROP -> DRAIN on rx_en=0 (sampled). DROP: drop_cnt++ at rx_en fall, then -> IDLE.
//    DRAIN: flush held bytes one per clk, then -> IDLE; rx inputs ignored (IFG >= 12 bytes covers drain).
//  - Delay line: 6-byte shift register. Once accepted, each new byte pushes and the oldest is emitted;
//    bytes 1..6 emitted in order (first with sof) as bytes 7..12 arrive. At DRAIN, remaining bytes emitted on
//    consecutive clks; STRIP_FCS=1 emits only 2 of 6 (last 4 discarded). eof/err/len on last emitted byte.
//  - Frame with <6 bytes at rx_en fall: nothing emitted, drop_cnt++. Frame of 6..MIN_LEN-1 bytes, accepted:
//    emitted with err=1. STRIP_FCS=1 with <=4 bytes left to emit: sof and eof on same byte if one byte.
//  - err sources: len<MIN_LEN; len>MAX_LEN (bytes still emitted); rx_er=1 at any sampled cycle in DATA;
//    DW4 odd nibble count at rx_en fall (partial byte discarded).
//  - out_len counts every assembled byte incl. FCS, saturates at 2047. frame_cnt++ on eof with err=0.
//  - rx_en=0 in PRE aborts silently; rx_er in PRE/IDLE ignored.
// STRUCTURE
//  - mii_defs.vh: state encodings (IDLE/PRE/DATA/DROP/DRAIN), PRE_NIB/SFD_NIB/PRE_BYTE/SFD_BYTE, BCAST_MAC,
//    ETH_MIN_LEN/ETH_MAX_LEN.
//  - Sub-module mii_byte_delay: 6x8 shift register with push/pop, occupancy count, flush; deframer holds FSM,
//    nibble assembly, filter compare, length/error tracking, counters.
// TESTING
//  - DW=4, 64-byte frame dst=54:ff:01:21:23:24, src=12:34:56:78:9a:bc, type 0x1234, 46-byte payload, 7x55 + D5 ->
//    64 out_valid, first 0x54 with sof, last eof, err=0, len=64, frame_cnt=1.
//  - Same with 32-byte payload (50 bytes) -> 50 bytes emitted, eof err=1 len=50, frame_cnt=0.
//  - dst=00:11:22:33:44:55, PROMISC=0 -> no out_valid, drop_cnt=1; PROMISC=1 -> 64 bytes; dst=ff:..:ff -> accepted.
//  - STRIP_FCS=1, 64-byte frame -> 60 bytes, last = final payload byte, len=64; rx_er pulse mid-payload -> err=1.
//  - DW=4 extra nibble before rx_en fall -> err=1, len=64; rx_en drop after 3 bytes -> nothing, drop_cnt++.
//  - SW0 pulse at byte 20 -> outputs 0, no eof; next good frame delivered; DW=8 run of test 1 -> identical output.

Source files
------------

// File: rtl/mii_rx_deframer_pkg.sv
`default_nettype none
//============================================================================
// mii_rx_deframer_pkg: shared types and constants for the MII/GMII deframer.
// Rev 1.0
//============================================================================
package mii_rx_deframer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRE   = 3'd1,
    ST_DATA  = 3'd2,
    ST_DROP  = 3'd3,
    ST_DRAIN = 3'd4
  } state_t;

  localparam logic [3:0]  PRE_NIB   = 4'h5;
  localparam logic [3:0]  SFD_NIB   = 4'hD;
  localparam logic [7:0]  PRE_BYTE  = 8'h55;
  localparam logic [7:0]  SFD_BYTE  = 8'hD5;
  localparam logic [47:0] BCAST_MAC = 48'hFFFF_FFFF_FFFF;

  localparam int ETH_MIN_LEN = 64;
  localparam int ETH_MAX_LEN = 1518;

  localparam int          LEN_W     = 11;
  localparam logic [10:0] LEN_SAT   = 11'h7FF;
  localparam logic [10:0] DA_BYTES  = 11'd6;
  localparam int          DLY_DEPTH = 6;
  localparam int          DLY_CNT_W = 3;
  localparam logic [2:0]  FCS_BYTES = 3'd4;

  // Wire-order byte of a MAC address: idx 0 is the first byte on the wire.
  function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [2:0] idx);
    case (idx)
      3'd0:    return mac[47:40];
      3'd1:    return mac[39:32];
      3'd2:    return mac[31:24];
      3'd3:    return mac[23:16];
      3'd4:    return mac[15:8];
      default: return mac[7:0];
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/mii_rx_deframer_byte_delay.sv
`default_nettype none
//============================================================================
// mii_rx_deframer_byte_delay: small byte shift register, newest at slot 0.
// Rev 1.0
//============================================================================
module mii_rx_deframer_byte_delay #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 6,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] head_o,
  output logic [CNT_W-1:0] count_o
);

  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (flush_i) begin
      count_d = '0;
    end else if (push_i && !pop_i && (count_q != FULL)) begin
      count_d = count_q + ONE;
    end else if (!push_i && pop_i && (count_q != '0)) begin
      count_d = count_q - ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      count_q <= count_d;
      if (push_i && !flush_i) begin
        mem_q[0] <= din_i;
        for (int i = 1; i < DEPTH; i++) begin
          mem_q[i] <= mem_q[i-1];
        end
      end
    end
  end

  // Oldest entry sits at slot count-1.
  always_comb begin
    head_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (count_q == CNT_W'(i + 1)) begin
        head_o = mem_q[i];
      end
    end
  end

  assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/mii_rx_deframer.sv
`default_nettype none
//============================================================================
// mii_rx_deframer: MII/GMII receive deframer with destination filter.
// Rev 1.0
//============================================================================
module mii_rx_deframer
  import mii_rx_deframer_pkg::*;
#(
  parameter int          DW        = 4,
  parameter logic [47:0] MAC_ADDR  = 48'h54ff01212324,
  parameter int          PROMISC   = 0,
  parameter int          STRIP_FCS = 0,
  parameter int          MIN_LEN   = ETH_MIN_LEN,
  parameter int          MAX_LEN   = ETH_MAX_LEN,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             SW0,
  input  logic             rx_ce,
  input  logic             rx_en,
  input  logic             rx_er,
  input  logic [DW-1:0]    rx_d,
  output logic [7:0]       out_data,
  output logic             out_valid,
  output logic             out_sof,
  output logic             out_eof,
  output logic             out_err,
  output logic [10:0]      out_len,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] drop_cnt
);

  localparam logic [10:0]      MIN_L   = 11'(MIN_LEN);
  localparam logic [10:0]      MAX_L   = 11'(MAX_LEN);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t state_q, state_d;
  logic [10:0]      len_q, len_d;
  logic             err_q, err_d;
  logic             ucast_q, ucast_d;
  logic             bcast_q, bcast_d;
  logic             mcast_q, mcast_d;
  logic             sof_pend_q, sof_pend_d;
  logic [2:0]       drain_left_q, drain_left_d;
  logic             fin_err_q, fin_err_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             sof_q, sof_d;
  logic             eof_q, eof_d;
  logic             oerr_q, oerr_d;
  logic [10:0]      olen_q, olen_d;

  logic       byte_last;
  logic [7:0] rx_byte;
  logic       odd_nib;
  logic       is_pre;
  logic       is_sfd;
  logic       dl_push, dl_pop, dl_flush;
  logic [7:0] dl_head;
  logic [2:0] dl_count;
  logic [10:0] len_inc;
  logic       match_u, match_b, accept;

  generate
    if (DW == 4) begin : g_mii
      logic [3:0] lo_q;
      logic       phase_q;
      // Low nibble arrives first; phase_q=1 means the next nibble completes a byte.
      always_ff @(posedge clk or posedge SW0) begin
        if (SW0) begin
          lo_q    <= '0;
          phase_q <= 1'b0;
        end else if (state_q != ST_DATA) begin
          phase_q <= 1'b0;
        end else if (rx_ce && rx_en) begin
          if (!phase_q) begin
            lo_q <= rx_d[3:0];
          end
          phase_q <= ~phase_q;
        end
      end
      assign byte_last = phase_q;
      assign rx_byte   = {rx_d[3:0], lo_q};
      assign odd_nib   = phase_q;
      assign is_pre    = (rx_d[3:0] == PRE_NIB);
      assign is_sfd    = (rx_d[3:0] == SFD_NIB);
    end else begin : g_gmii
      assign byte_last = 1'b1;
      assign rx_byte   = rx_d[7:0];
      assign odd_nib   = 1'b0;
      assign is_pre    = (rx_d[7:0] == PRE_BYTE);
      assign is_sfd    = (rx_d[7:0] == SFD_BYTE);
    end
  endgenerate

  assign len_inc = (len_q == LEN_SAT) ? len_q : len_q + 11'd1;
  assign match_u = ucast_q & (rx_byte == mac_byte(MAC_ADDR, len_q[2:0]));
  assign match_b = bcast_q & (rx_byte == mac_byte(BCAST_MAC, len_q[2:0]));
  assign accept  = match_u | match_b | mcast_q | (PROMISC != 0);

  mii_rx_deframer_byte_delay #(
    .WIDTH (8),
    .DEPTH (DLY_DEPTH),
    .CNT_W (DLY_CNT_W)
  ) u_delay (
    .clk     (clk),
    .rst     (SW0),
    .push_i  (dl_push),
    .pop_i   (dl_pop),
    .flush_i (dl_flush),
    .din_i   (rx_byte),
    .head_o  (dl_head),
    .count_o (dl_count)
  );

  always_ff @(posedge clk or posedge SW0) begin
    if (SW0) begin
      state_q      <= ST_IDLE;
      len_q        <= '0;
      err_q        <= 1'b0;
      ucast_q      <= 1'b0;
      bcast_q      <= 1'b0;
      mcast_q      <= 1'b0;
      sof_pend_q   <= 1'b0;
      drain_left_q <= '0;
      fin_err_q    <= 1'b0;
      frame_cnt_q  <= '0;
      drop_cnt_q   <= '0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      sof_q        <= 1'b0;
      eof_q        <= 1'b0;
      oerr_q       <= 1'b0;
      olen_q       <= '0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      err_q        <= err_d;
      ucast_q      <= ucast_d;
      bcast_q      <= bcast_d;
      mcast_q      <= mcast_d;
      sof_pend_q   <= sof_pend_d;
      drain_left_q <= drain_left_d;
      fin_err_q    <= fin_err_d;
      frame_cnt_q  <= frame_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      sof_q        <= sof_d;
      eof_q        <= eof_d;
      oerr_q       <= oerr_d;
      olen_q       <= olen_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    err_d        = err_q;
    ucast_d      = ucast_q;
    bcast_d      = bcast_q;
    mcast_d      = mcast_q;
    sof_pend_d   = sof_pend_q;
    drain_left_d = drain_left_q;
    fin_err_d    = fin_err_q;
    frame_cnt_d  = frame_cnt_q;
    drop_cnt_d   = drop_cnt_q;
    data_d       = data_q;
    valid_d      = 1'b0;
    sof_d        = 1'b0;
    eof_d        = 1'b0;
    oerr_d       = 1'b0;
    olen_d       = '0;
    dl_push      = 1'b0;
    dl_pop       = 1'b0;
    dl_flush     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (rx_ce && rx_en && is_pre) begin
          state_d = ST_PRE;
        end
      end

      ST_PRE: begin
        if (rx_ce) begin
          if (!rx_en) begin
            state_d = ST_IDLE;
          end else if (is_sfd) begin
            state_d    = ST_DATA;
            len_d      = '0;
            err_d      = 1'b0;
            ucast_d    = 1'b1;
            bcast_d    = 1'b1;
            mcast_d    = 1'b0;
            sof_pend_d = 1'b1;
            dl_flush   = 1'b1;
          end else if (!is_pre) begin
            state_d = ST_IDLE;
          end
        end
      end

      ST_DATA: begin
        if (rx_ce) begin
          if (rx_er) begin
            err_d = 1'b1;
          end
          if (!rx_en) begin
            if (len_q < DA_BYTES) begin
              drop_cnt_d = drop_cnt_q + CNT_ONE;
              dl_flush   = 1'b1;
              state_d    = ST_IDLE;
            end else begin
              state_d   = ST_DRAIN;
              fin_err_d = err_q | rx_er | (len_q < MIN_L) | (len_q > MAX_L) | odd_nib;
              if (STRIP_FCS != 0) begin
                drain_left_d = (dl_count > FCS_BYTES) ? dl_count - FCS_BYTES : 3'd0;
              end else begin
                drain_left_d = dl_count;
              end
            end
          end else if (byte_last) begin
            len_d   = len_inc;
            dl_push = 1'b1;
            if (len_q < DA_BYTES) begin
              ucast_d = match_u;
              bcast_d = match_b;
              if (len_q == 11'd0) begin
                mcast_d = rx_byte[0];
              end
              if ((len_q == DA_BYTES - 11'd1) && !accept) begin
                state_d  = ST_DROP;
                dl_flush = 1'b1;
              end
            end else begin
              // Line is full: the new byte pushes the oldest one out.
              dl_pop     = 1'b1;
              valid_d    = 1'b1;
              data_d     = dl_head;
              sof_d      = sof_pend_q;
              sof_pend_d = 1'b0;
            end
          end
        end
      end

      ST_DROP: begin
        if (rx_ce && !rx_en) begin
          drop_cnt_d = drop_cnt_q + CNT_ONE;
          state_d    = ST_IDLE;
        end
      end

      ST_DRAIN: begin
        if (drain_left_q == 3'd0) begin
          dl_flush = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          dl_pop       = 1'b1;
          valid_d      = 1'b1;
          data_d       = dl_head;
          sof_d        = sof_pend_q;
          sof_pend_d   = 1'b0;
          drain_left_d = drain_left_q - 3'd1;
          if (drain_left_q == 3'd1) begin
            eof_d    = 1'b1;
            oerr_d   = fin_err_q;
            olen_d   = len_q;
            dl_flush = 1'b1;
            state_d  = ST_IDLE;
            if (!fin_err_q) begin
              frame_cnt_d = frame_cnt_q + CNT_ONE;
            end
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign out_sof   = sof_q;
  assign out_eof   = eof_q;
  assign out_err   = oerr_q;
  assign out_len   = olen_q;
  assign frame_cnt = frame_cnt_q;
  assign drop_cnt  = drop_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_mii_rx_deframer.sv
`default_nettype none
//============================================================================
// tb_mii_rx_deframer: four deframer configurations driven in lockstep
// (MII, MII promiscuous, MII FCS-strip, GMII) checked against a scoreboard.
//============================================================================
module tb_mii_rx_deframer;

  typedef struct packed {
    logic [7:0]  d;
    logic        sof;
    logic        eof;
    logic        err;
    logic [10:0] len;
  } exp_t;

  localparam logic [47:0] MAC = 48'h54ff01212324;

  logic       clk;
  logic       SW0;
  logic       ce_m, ce_g;
  logic       rx_en, rx_er;
  logic [3:0] rx_d4;
  logic [7:0] rx_d8;

  logic [7:0]  o_data  [4];
  logic        o_valid [4];
  logic        o_sof   [4];
  logic        o_eof   [4];
  logic        o_err   [4];
  logic [10:0] o_len   [4];
  logic [15:0] o_fcnt  [4];
  logic [15:0] o_dcnt  [4];

  bit cfg_prom  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
  bit cfg_strip [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
  bit cfg_gmii  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

  exp_t       sb_q [4][$];
  int         exp_frame [4];
  int         exp_drop  [4];
  logic [7:0] fb [2048];
  int         total = 0;
  int         bad   = 0;
  exp_t       mon_x;

  mii_rx_deframer #(.DW(4)) u_mii (
    .clk(clk), .SW0(SW0), .rx_ce(ce_m), .rx_en(rx_en), .rx_er(rx_er), .rx_d(rx_d4),
    .out_data(o_data[0]), .out_valid(o_valid[0]), .out_sof(o_sof[0]), .out_eof(o_eof[0]),
    .out_err(o_err[0]), .out_len(o_len[0]), .frame_cnt(o_fcnt[0]), .drop_cnt(o_dcnt[0]));

  mii_rx_deframer #(.DW(4), .PROMISC(1)) u_prom (
    .clk(clk), .SW0(SW0), .rx_ce(ce_m), .rx_en(rx_en), .rx_er(rx_er), .rx_d(rx_d4),
    .out_data(o_data[1]), .out_valid(o_valid[1]), .out_sof(o_sof[1]), .out_eof(o_eof[1]),
    .out_err(o_err[1]), .out_len(o_len[1]), .frame_cnt(o_fcnt[1]), .drop_cnt(o_dcnt[1]));

  mii_rx_deframer #(.DW(4), .STRIP_FCS(1)) u_strip (
    .clk(clk), .SW0(SW0), .rx_ce(ce_m), .rx_en(rx_en), .rx_er(rx_er), .rx_d(rx_d4),
    .out_data(o_data[2]), .out_valid(o_valid[2]), .out_sof(o_sof[2]), .out_eof(o_eof[2]),
    .out_err(o_err[2]), .out_len(o_len[2]), .frame_cnt(o_fcnt[2]), .drop_cnt(o_dcnt[2]));

  mii_rx_deframer #(.DW(8)) u_gmii (
    .clk(clk), .SW0(SW0), .rx_ce(ce_g), .rx_en(rx_en), .rx_er(rx_er), .rx_d(rx_d8),
    .out_data(o_data[3]), .out_valid(o_valid[3]), .out_sof(o_sof[3]), .out_eof(o_eof[3]),
    .out_err(o_err[3]), .out_len(o_len[3]), .frame_cnt(o_fcnt[3]), .drop_cnt(o_dcnt[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Output monitor: every emitted byte must match the head of its queue.
  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (o_valid[k]) begin
        if (sb_q[k].size() == 0) begin
          check($sformatf("d%0d_extra", k), 32'(o_valid[k]), 32'd0);
        end else begin
          mon_x = sb_q[k].pop_front();
          check($sformatf("d%0d_data", k), 32'(o_data[k]), 32'(mon_x.d));
          check($sformatf("d%0d_sof", k), 32'(o_sof[k]), 32'(mon_x.sof));
          check($sformatf("d%0d_eof", k), 32'(o_eof[k]), 32'(mon_x.eof));
          if (mon_x.eof) begin
            check($sformatf("d%0d_err", k), 32'(o_err[k]), 32'(mon_x.err));
            check($sformatf("d%0d_len", k), 32'(o_len[k]), 32'(mon_x.len));
          end
        end
      end
    end
  end

  task automatic build(input logic [47:0] dst, input int plen);
    logic [47:0] src;
    src = 48'h123456789abc;
    for (int i = 0; i < 6; i++) begin
      fb[i]     = dst[47-8*i -: 8];
      fb[6 + i] = src[47-8*i -: 8];
    end
    fb[12] = 8'h12;
    fb[13] = 8'h34;
    for (int i = 0; i < plen; i++) fb[14 + i] = 8'(i * 7 + 3);
    for (int j = 0; j < 4; j++) fb[14 + plen + j] = 8'(8'hA0 + j);
  endtask

  task automatic model(input int nb, input bit odd, input bit er);
    logic [47:0] m;
    bit   ucast, bcast, acc, e;
    int   cnt;
    exp_t x;
    m = MAC;
    ucast = 1'b1;
    bcast = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (fb[i] != m[47-8*i -: 8]) ucast = 1'b0;
      if (fb[i] != 8'hFF) bcast = 1'b0;
    end
    for (int k = 0; k < 4; k++) begin
      acc = (nb >= 6) && (ucast || bcast || fb[0][0] || cfg_prom[k]);
      if (!acc) begin
        exp_drop[k]++;
      end else begin
        e   = (nb < 64) || (nb > 1518) || er || (odd && !cfg_gmii[k]);
        cnt = cfg_strip[k] ? nb - 4 : nb;
        for (int i = 0; i < cnt; i++) begin
          x.d   = fb[i];
          x.sof = (i == 0);
          x.eof = (i == cnt - 1);
          x.err = e;
          x.len = 11'((nb > 2047) ? 2047 : nb);
          sb_q[k].push_back(x);
        end
        if (!e) exp_frame[k]++;
      end
    end
  endtask

  task automatic strobe(input logic [3:0] n4, input logic [7:0] b8, input bit g);
    rx_d4 = n4;
    rx_d8 = b8;
    ce_m  = 1'b1;
    ce_g  = g;
    @(posedge clk); #1;
    ce_m  = 1'b0;
    ce_g  = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    repeat (3) @(posedge clk);
    #1 SW0 = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("d%0d_rst_valid", k), 32'(o_valid[k]), 32'd0);
      check($sformatf("d%0d_rst_data", k), 32'(o_data[k]), 32'd0);
      check($sformatf("d%0d_rst_fcnt", k), 32'(o_fcnt[k]), 32'd0);
      check($sformatf("d%0d_rst_dcnt", k), 32'(o_dcnt[k]), 32'd0);
    end
    @(posedge clk); #1;
    SW0   = 1'b0;
    rx_en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      sb_q[k].delete();
      exp_frame[k] = 0;
      exp_drop[k]  = 0;
    end
  endtask

  task automatic send(input int nb, input int er_at, input bit extra, input int rst_at);
    logic [7:0] b;
    rx_en = 1'b1;
    for (int p = 0; p < 8; p++) begin
      b = (p < 7) ? 8'h55 : 8'hD5;
      strobe(b[3:0], b, 1'b0);
      strobe(b[7:4], b, 1'b1);
    end
    for (int i = 0; i < nb; i++) begin
      if (i == rst_at) begin
        do_reset();
        return;
      end
      rx_er = (i == er_at);
      b = fb[i];
      strobe(b[3:0], b, 1'b0);
      strobe(b[7:4], b, 1'b1);
    end
    rx_er = 1'b0;
    if (extra) strobe(4'hA, 8'h00, 1'b0);
    rx_en = 1'b0;
    strobe(4'h0, 8'h00, 1'b1);
  endtask

  task automatic settle();
    repeat (40) @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("d%0d_left", k), 32'(sb_q[k].size()), 32'd0);
      check($sformatf("d%0d_fcnt", k), 32'(o_fcnt[k]), 32'(exp_frame[k]));
      check($sformatf("d%0d_dcnt", k), 32'(o_dcnt[k]), 32'(exp_drop[k]));
    end
  endtask

  initial begin
    SW0 = 1'b1; ce_m = 1'b0; ce_g = 1'b0; rx_en = 1'b0; rx_er = 1'b0;
    rx_d4 = '0; rx_d8 = '0;
    for (int k = 0; k < 4; k++) begin
      exp_frame[k] = 0;
      exp_drop[k]  = 0;
    end
    repeat (2) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("d%0d_init_valid", k), 32'(o_valid[k]), 32'd0);
      check($sformatf("d%0d_init_len", k), 32'(o_len[k]), 32'd0);
      check($sformatf("d%0d_init_fcnt", k), 32'(o_fcnt[k]), 32'd0);
      check($sformatf("d%0d_init_dcnt", k), 32'(o_dcnt[k]), 32'd0);
    end
    @(posedge clk); #1 SW0 = 1'b0;
    repeat (4) @(posedge clk); #1;

    build(MAC, 46);               model(64, 1'b0, 1'b0);   send(64, -1, 1'b0, -1);   settle();
    build(MAC, 32);               model(50, 1'b0, 1'b0);   send(50, -1, 1'b0, -1);   settle();
    build(48'h001122334455, 46);  model(64, 1'b0, 1'b0);   send(64, -1, 1'b0, -1);   settle();
    build(48'hFFFFFFFFFFFF, 46);  model(64, 1'b0, 1'b0);   send(64, -1, 1'b0, -1);   settle();
    build(MAC, 46);               model(64, 1'b0, 1'b1);   send(64, 30, 1'b0, -1);   settle();
    build(MAC, 46);               model(64, 1'b1, 1'b0);   send(64, -1, 1'b1, -1);   settle();
    build(MAC, 46);               model(3, 1'b0, 1'b0);    send(3, -1, 1'b0, -1);    settle();
    build(MAC, 1502);             model(1520, 1'b0, 1'b0); send(1520, -1, 1'b0, -1); settle();
    build(MAC, 46);               model(64, 1'b0, 1'b0);   send(64, -1, 1'b0, 20);   settle();
    build(MAC, 46);               model(64, 1'b0, 1'b0);   send(64, -1, 1'b0, -1);   settle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
